// File: rtl/load_store_unit.sv
// load_store_unit: RISC-V load/store to word-aligned bus beats with misaligned split, stall and extension
module load_store_unit #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 memRead,
  input  logic                 memWrite,
  input  logic [2:0]           func3,
  input  logic [AddrWidth-1:0] memAddr,
  input  logic [DataWidth-1:0] memWriteData,
  output logic                 stall,
  output logic [DataWidth-1:0] memReadData,
  output logic                 loadValid,
  output logic                 accessErr,
  output logic                 busReq,
  output logic                 busWe,
  output logic [AddrWidth-1:0] busAddr,
  output logic [3:0]           busByteEn,
  output logic [DataWidth-1:0] busWData,
  input  logic                 busAck,
  input  logic [DataWidth-1:0] busRData
);
  typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] off_q, off_d;
  logic [2:0] f3_q, f3_d;
  logic [DataWidth-1:0] data_q, data_d, rbuf_q, rbuf_d;
  logic bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [AddrWidth-1:0] bus_addr_q, bus_addr_d;
  logic [3:0] bus_byte_en_q, bus_byte_en_d;
  logic [DataWidth-1:0] bus_wdata_q, bus_wdata_d, mem_read_data_q, mem_read_data_d;
  logic load_valid_q, load_valid_d, access_err_q, access_err_d;
  logic req, legal, fin;
  logic [1:0] off;
  logic [2:0] f3;
  logic [DataWidth-1:0] data, rd_shift, load_res;
  logic [3:0] size_mask;
  logic [7:0] lane_mask;
  logic [63:0] lane_data, rd_wide;
  assign req = memRead | memWrite;
  assign stall = req && state_q != DONE;
  // In IDLE the lane masks come straight from the request; afterwards from the latched copy
  assign off = state_q == IDLE ? memAddr[1:0] : off_q;
  assign f3 = state_q == IDLE ? func3 : f3_q;
  assign data = state_q == IDLE ? memWriteData : data_q;
  assign size_mask = f3[1] ? 4'hF : f3[0] ? 4'h3 : 4'h1;
  assign lane_mask = 8'({4'b0, size_mask} << off);
  assign lane_data = {32'b0, data} << {off, 3'b000};
  assign legal = memWrite ? (!func3[2] && func3[1:0] != 2'b11) : !(func3[1] && (func3[0] || func3[2]));
  // The final beat's data is used directly so the result is ready in the DONE cycle
  assign rd_wide = state_q == SECOND ? {busRData, rbuf_q} : {32'b0, busRData};
  assign rd_shift = 32'(rd_wide >> {off_q, 3'b000});
  assign load_res = f3_q[1:0] == 2'd0 ? {{24{~f3_q[2] & rd_shift[7]}}, rd_shift[7:0]}
                  : f3_q[1:0] == 2'd1 ? {{16{~f3_q[2] & rd_shift[15]}}, rd_shift[15:0]}
                  : rd_shift;
  assign busReq = bus_req_q;
  assign busWe = bus_we_q;
  assign busAddr = bus_addr_q;
  assign busByteEn = bus_byte_en_q;
  assign busWData = bus_wdata_q;
  assign memReadData = mem_read_data_q;
  assign loadValid = load_valid_q;
  assign accessErr = access_err_q;
  // Next state and next registered bus/result outputs
  always_comb begin
    state_d = state_q;
    off_d = off_q;
    f3_d = f3_q;
    data_d = data_q;
    rbuf_d = rbuf_q;
    bus_req_d = bus_req_q;
    bus_we_d = bus_we_q;
    bus_addr_d = bus_addr_q;
    bus_byte_en_d = bus_byte_en_q;
    bus_wdata_d = bus_wdata_q;
    mem_read_data_d = mem_read_data_q;
    load_valid_d = 1'b0;
    access_err_d = 1'b0;
    fin = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        off_d = memAddr[1:0];
        f3_d = func3;
        data_d = memWriteData;
        bus_we_d = memWrite;
        if (!legal) begin
          state_d = DONE;
          access_err_d = 1'b1;
        end else begin
          state_d = FIRST;
          bus_req_d = 1'b1;
          bus_addr_d = {memAddr[AddrWidth-1:2], 2'b00};
          bus_byte_en_d = lane_mask[3:0];
          bus_wdata_d = lane_data[31:0];
        end
      end
      FIRST: if (busAck) begin
        rbuf_d = busRData;
        if (lane_mask[7:4] != 4'h0) begin
          state_d = SECOND;
          bus_addr_d = bus_addr_q + AddrWidth'(4);
          bus_byte_en_d = lane_mask[7:4];
          bus_wdata_d = lane_data[63:32];
        end else begin
          state_d = DONE;
          bus_req_d = 1'b0;
          fin = 1'b1;
        end
      end
      SECOND: if (busAck) begin
        state_d = DONE;
        bus_req_d = 1'b0;
        fin = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (fin && !bus_we_q) begin
      load_valid_d = 1'b1;
      mem_read_data_d = load_res;
    end
  end
  // State and output registers, cleared asynchronously so a reset abandons any beat at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      off_q <= '0;
      f3_q <= '0;
      data_q <= '0;
      rbuf_q <= '0;
      bus_req_q <= 1'b0;
      bus_we_q <= 1'b0;
      bus_addr_q <= '0;
      bus_byte_en_q <= '0;
      bus_wdata_q <= '0;
      mem_read_data_q <= '0;
      load_valid_q <= 1'b0;
      access_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q <= off_d;
      f3_q <= f3_d;
      data_q <= data_d;
      rbuf_q <= rbuf_d;
      bus_req_q <= bus_req_d;
      bus_we_q <= bus_we_d;
      bus_addr_q <= bus_addr_d;
      bus_byte_en_q <= bus_byte_en_d;
      bus_wdata_q <= bus_wdata_d;
      mem_read_data_q <= mem_read_data_d;
      load_valid_q <= load_valid_d;
      access_err_q <= access_err_d;
    end
  end
endmodule
